// File: rtl/SH7604_PKG.sv
// rtl/SH7604_PKG.sv - shared register types, constants and helpers for the on-chip interrupt controller
package SH7604_PKG;

    typedef struct packed {
        logic [3:0] divu;
        logic [3:0] dmac;
        logic [3:0] wdt;
        logic [3:0] rsv;
    } IPRA_t;

    typedef struct packed {
        logic [3:0] sci;
        logic [3:0] frt;
        logic [7:0] rsv;
    } IPRB_t;

    typedef struct packed {
        logic       rsv_h;
        logic [6:0] vh;
        logic       rsv_l;
        logic [6:0] vl;
    } VCR_t;

    typedef struct packed {
        logic       nmil;
        logic [5:0] rsv_h;
        logic       nmie;
        logic [6:0] rsv_l;
        logic       vecmd;
    } ICR_t;

    typedef enum logic [3:0] {
        REG_NONE, REG_ICR, REG_IPRA, REG_VCRWDT, REG_IPRB,
        REG_VCRA, REG_VCRB, REG_VCRC, REG_VCRD
    } reg_sel_e;

    localparam logic [31:0] ICR_ADDR    = 32'hFFFFFEE0;
    localparam logic [31:0] IPRA_ADDR   = 32'hFFFFFEE2;
    localparam logic [31:0] VCRWDT_ADDR = 32'hFFFFFEE4;
    localparam logic [31:0] IPRB_ADDR   = 32'hFFFFFE60;
    localparam logic [31:0] VCRA_ADDR   = 32'hFFFFFE62;
    localparam logic [31:0] VCRB_ADDR   = 32'hFFFFFE64;
    localparam logic [31:0] VCRC_ADDR   = 32'hFFFFFE66;
    localparam logic [31:0] VCRD_ADDR   = 32'hFFFFFE68;

    localparam logic [15:0] IPRA_INIT  = 16'h0000;
    localparam logic [15:0] IPRB_INIT  = 16'h0000;
    localparam logic [15:0] VCR_INIT   = 16'h0000;
    localparam logic [15:0] ICR_INIT   = 16'h0000;

    // ICR[15] is the live pin level, so it is never stored
    localparam logic [15:0] ICR_WMASK  = 16'h0101;
    localparam logic [15:0] IPRA_WMASK = 16'hFFF0;
    localparam logic [15:0] IPRB_WMASK = 16'hFF00;
    localparam logic [15:0] VCR_WMASK  = 16'h7F7F;
    localparam logic [15:0] VCRD_WMASK = 16'h7F00;
    localparam logic [15:0] ICR_RMASK  = 16'h8101;

    localparam logic [7:0] NMI_VEC      = 8'd11;
    localparam logic [7:0] IRL_VEC_BASE = 8'd64;
    localparam logic [4:0] NMI_LVL      = 5'd16;

    localparam int NUM_SRC = 14;
    localparam int SRC_NMI = 0,  SRC_IRL = 1,  SRC_DIVU = 2, SRC_DMA0 = 3, SRC_DMA1 = 4;
    localparam int SRC_ITI = 5,  SRC_CMI = 6,  SRC_ERI = 7,  SRC_RXI = 8,  SRC_TXI = 9;
    localparam int SRC_TEI = 10, SRC_ICI = 11, SRC_OCI = 12, SRC_OVI = 13;

    function automatic reg_sel_e decode_addr(input logic [31:0] a);
        logic [31:0] h;
        h = {a[31:1], 1'b0};
        case (h)
            ICR_ADDR:    return REG_ICR;
            IPRA_ADDR:   return REG_IPRA;
            VCRWDT_ADDR: return REG_VCRWDT;
            IPRB_ADDR:   return REG_IPRB;
            VCRA_ADDR:   return REG_VCRA;
            VCRB_ADDR:   return REG_VCRB;
            VCRC_ADDR:   return REG_VCRC;
            VCRD_ADDR:   return REG_VCRD;
            default:     return REG_NONE;
        endcase
    endfunction

    function automatic logic [15:0] reg_write(input logic [15:0] cur, input logic [15:0] wd,
                                              input logic [15:0] mask, input logic [1:0] be);
        logic [15:0] m;
        m = mask & {{8{be[1]}}, {8{be[0]}}};
        return (cur & ~m) | (wd & m);
    endfunction

endpackage

// File: rtl/intc_prio_arb.sv
// rtl/intc_prio_arb.sv - combinational highest-level winner over the ordered source list
module intc_prio_arb
    import SH7604_PKG::*;
(
    input  logic [NUM_SRC-1:0]      src_act,
    input  logic [NUM_SRC-1:0][4:0] src_lvl,
    input  logic [NUM_SRC-1:0][7:0] src_vec,
    output logic                    req,
    output logic [4:0]              lvl,
    output logic [7:0]              vec
);

    logic [4:0] best_lvl;
    logic [7:0] best_vec;

    // Strict compare: on a tie the earlier (higher fixed priority) source keeps the win
    always_comb begin
        best_lvl = '0;
        best_vec = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_act[i] && (src_lvl[i] > best_lvl)) begin
                best_lvl = src_lvl[i];
                best_vec = src_vec[i];
            end
        end
    end

    assign req = (best_lvl != 5'd0);
    assign lvl = best_lvl;
    assign vec = best_vec;

endmodule

// File: rtl/intc_onchip.sv
// rtl/intc_onchip.sv - on-chip interrupt controller: registers, NMI edge detect, registered arbitration
module intc_onchip
    import SH7604_PKG::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_R,
    input  logic        CE_F,
    input  logic        RES_N,
    input  logic [31:0] IBUS_A,
    input  logic [31:0] IBUS_DI,
    output logic [31:0] IBUS_DO,
    input  logic [3:0]  IBUS_BA,
    input  logic        IBUS_WE,
    input  logic        IBUS_REQ,
    output logic        IBUS_BUSY,
    output logic        IBUS_ACT,
    input  logic        NMI,
    input  logic [3:0]  IRL,
    input  logic        FRT_ICI,
    input  logic        FRT_OCIA,
    input  logic        FRT_OCIB,
    input  logic        FRT_OVI,
    input  logic        WDT_ITI,
    input  logic        BSC_CMI,
    input  logic        SCI_ERI,
    input  logic        SCI_RXI,
    input  logic        SCI_TXI,
    input  logic        SCI_TEI,
    input  logic        DIVU_IRQ,
    input  logic        DMA0_IRQ,
    input  logic        DMA1_IRQ,
    input  logic [7:0]  DIVU_VEC,
    input  logic [7:0]  DMA0_VEC,
    input  logic [7:0]  DMA1_VEC,
    input  logic        INT_ACK,
    output logic        INT_REQ,
    output logic [4:0]  INT_LVL,
    output logic [7:0]  INT_VEC,
    output logic        NMI_ACT
);

    IPRA_t    ipra;
    IPRB_t    iprb;
    ICR_t     icr;
    VCR_t     vcra, vcrb, vcrc, vcrd, vcrwdt;
    reg_sel_e reg_sel;
    logic        hit;
    logic [15:0] wdata, rdata;
    logic [1:0]  wbe;
    logic        nmi_prev, nmi_flag, nmi_edge;
    logic [3:0]  irl_lvl;
    logic [7:0]  irl_vec;
    logic [NUM_SRC-1:0]      src_act;
    logic [NUM_SRC-1:0][4:0] src_lvl;
    logic [NUM_SRC-1:0][7:0] src_vec;
    logic        arb_req;
    logic [4:0]  arb_lvl;
    logic [7:0]  arb_vec;

    assign IBUS_BUSY = 1'b0;
    assign reg_sel   = decode_addr(IBUS_A);
    assign hit       = IBUS_REQ && (reg_sel != REG_NONE);
    assign IBUS_ACT  = hit;
    // Halfword at A[1]=0 rides the upper data lanes, A[1]=1 the lower ones
    assign wdata     = IBUS_A[1] ? IBUS_DI[15:0] : IBUS_DI[31:16];
    assign wbe       = IBUS_A[1] ? IBUS_BA[1:0]  : IBUS_BA[3:2];

    always_comb begin
        rdata = 16'h0000;
        case (reg_sel)
            REG_ICR:    rdata = (icr | {NMI, 15'd0}) & ICR_RMASK;
            REG_IPRA:   rdata = ipra;
            REG_VCRWDT: rdata = vcrwdt;
            REG_IPRB:   rdata = iprb;
            REG_VCRA:   rdata = vcra;
            REG_VCRB:   rdata = vcrb;
            REG_VCRC:   rdata = vcrc;
            REG_VCRD:   rdata = vcrd;
            default:    rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            icr  <= ICR_INIT;   ipra <= IPRA_INIT;  iprb <= IPRB_INIT;
            vcra <= VCR_INIT;   vcrb <= VCR_INIT;   vcrc <= VCR_INIT;
            vcrd <= VCR_INIT;   vcrwdt <= VCR_INIT;
        end else if (CE_R) begin
            if (!RES_N) begin
                icr  <= ICR_INIT;   ipra <= IPRA_INIT;  iprb <= IPRB_INIT;
                vcra <= VCR_INIT;   vcrb <= VCR_INIT;   vcrc <= VCR_INIT;
                vcrd <= VCR_INIT;   vcrwdt <= VCR_INIT;
            end else if (hit && IBUS_WE) begin
                case (reg_sel)
                    REG_ICR:    icr    <= ICR_t'(reg_write(icr, wdata, ICR_WMASK, wbe));
                    REG_IPRA:   ipra   <= IPRA_t'(reg_write(ipra, wdata, IPRA_WMASK, wbe));
                    REG_VCRWDT: vcrwdt <= VCR_t'(reg_write(vcrwdt, wdata, VCR_WMASK, wbe));
                    REG_IPRB:   iprb   <= IPRB_t'(reg_write(iprb, wdata, IPRB_WMASK, wbe));
                    REG_VCRA:   vcra   <= VCR_t'(reg_write(vcra, wdata, VCR_WMASK, wbe));
                    REG_VCRB:   vcrb   <= VCR_t'(reg_write(vcrb, wdata, VCR_WMASK, wbe));
                    REG_VCRC:   vcrc   <= VCR_t'(reg_write(vcrc, wdata, VCR_WMASK, wbe));
                    REG_VCRD:   vcrd   <= VCR_t'(reg_write(vcrd, wdata, VCRD_WMASK, wbe));
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            IBUS_DO <= '0;
        else if (CE_F)
            IBUS_DO <= hit ? {rdata, rdata} : 32'd0;
    end

    assign nmi_edge = icr.nmie ? (NMI && !nmi_prev) : (!NMI && nmi_prev);

    // A fresh edge beats a simultaneous acknowledge so no NMI is lost
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            nmi_prev <= 1'b0;
            nmi_flag <= 1'b0;
        end else if (CE_R) begin
            nmi_prev <= NMI;
            if (!RES_N)
                nmi_flag <= 1'b0;
            else if (nmi_edge)
                nmi_flag <= 1'b1;
            else if (INT_ACK && (INT_LVL == NMI_LVL))
                nmi_flag <= 1'b0;
        end
    end

    assign NMI_ACT = nmi_flag;
    assign irl_lvl = ~IRL;
    assign irl_vec = icr.vecmd ? (IRL_VEC_BASE + {4'd0, irl_lvl})
                               : (IRL_VEC_BASE + {5'd0, irl_lvl[3:1]});

    always_comb begin
        src_act = '0;
        src_lvl = '0;
        src_vec = '0;
        src_act[SRC_NMI]  = nmi_flag;  src_lvl[SRC_NMI]  = NMI_LVL;           src_vec[SRC_NMI]  = NMI_VEC;
        src_act[SRC_IRL]  = (IRL != 4'hF); src_lvl[SRC_IRL] = {1'b0, irl_lvl}; src_vec[SRC_IRL] = irl_vec;
        src_act[SRC_DIVU] = DIVU_IRQ;  src_lvl[SRC_DIVU] = {1'b0, ipra.divu}; src_vec[SRC_DIVU] = DIVU_VEC;
        src_act[SRC_DMA0] = DMA0_IRQ;  src_lvl[SRC_DMA0] = {1'b0, ipra.dmac}; src_vec[SRC_DMA0] = DMA0_VEC;
        src_act[SRC_DMA1] = DMA1_IRQ;  src_lvl[SRC_DMA1] = {1'b0, ipra.dmac}; src_vec[SRC_DMA1] = DMA1_VEC;
        src_act[SRC_ITI]  = WDT_ITI;   src_lvl[SRC_ITI]  = {1'b0, ipra.wdt};  src_vec[SRC_ITI]  = {1'b0, vcrwdt.vh};
        src_act[SRC_CMI]  = BSC_CMI;   src_lvl[SRC_CMI]  = {1'b0, ipra.wdt};  src_vec[SRC_CMI]  = {1'b0, vcrwdt.vl};
        src_act[SRC_ERI]  = SCI_ERI;   src_lvl[SRC_ERI]  = {1'b0, iprb.sci};  src_vec[SRC_ERI]  = {1'b0, vcra.vh};
        src_act[SRC_RXI]  = SCI_RXI;   src_lvl[SRC_RXI]  = {1'b0, iprb.sci};  src_vec[SRC_RXI]  = {1'b0, vcra.vl};
        src_act[SRC_TXI]  = SCI_TXI;   src_lvl[SRC_TXI]  = {1'b0, iprb.sci};  src_vec[SRC_TXI]  = {1'b0, vcrb.vh};
        src_act[SRC_TEI]  = SCI_TEI;   src_lvl[SRC_TEI]  = {1'b0, iprb.sci};  src_vec[SRC_TEI]  = {1'b0, vcrb.vl};
        src_act[SRC_ICI]  = FRT_ICI;   src_lvl[SRC_ICI]  = {1'b0, iprb.frt};  src_vec[SRC_ICI]  = {1'b0, vcrc.vh};
        src_act[SRC_OCI]  = FRT_OCIA || FRT_OCIB;
        src_lvl[SRC_OCI]  = {1'b0, iprb.frt};  src_vec[SRC_OCI]  = {1'b0, vcrc.vl};
        src_act[SRC_OVI]  = FRT_OVI;   src_lvl[SRC_OVI]  = {1'b0, iprb.frt};  src_vec[SRC_OVI]  = {1'b0, vcrd.vh};
    end

    intc_prio_arb u_arb (
        .src_act (src_act),
        .src_lvl (src_lvl),
        .src_vec (src_vec),
        .req     (arb_req),
        .lvl     (arb_lvl),
        .vec     (arb_vec)
    );

    // Outputs freeze for the acknowledge cycle so the CPU samples a stable level/vector
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            INT_REQ <= 1'b0;
            INT_LVL <= '0;
            INT_VEC <= '0;
        end else if (CE_R) begin
            if (!RES_N) begin
                INT_REQ <= 1'b0;
                INT_LVL <= '0;
                INT_VEC <= '0;
            end else if (!INT_ACK) begin
                INT_REQ <= arb_req;
                INT_LVL <= arb_lvl;
                INT_VEC <= arb_vec;
            end
        end
    end

endmodule

// File: tb/tb_intc_onchip.sv
// tb/tb_intc_onchip.sv - directed self-checking bench for intc_onchip
module tb_intc_onchip;

    logic        CLK = 1'b0;
    logic        RST, CE_R, CE_F, RES_N;
    logic [31:0] IBUS_A, IBUS_DI, IBUS_DO;
    logic [3:0]  IBUS_BA;
    logic        IBUS_WE, IBUS_REQ, IBUS_BUSY, IBUS_ACT;
    logic        NMI;
    logic [3:0]  IRL;
    logic        FRT_ICI, FRT_OCIA, FRT_OCIB, FRT_OVI;
    logic        WDT_ITI, BSC_CMI, SCI_ERI, SCI_RXI, SCI_TXI, SCI_TEI;
    logic        DIVU_IRQ, DMA0_IRQ, DMA1_IRQ;
    logic [7:0]  DIVU_VEC, DMA0_VEC, DMA1_VEC;
    logic        INT_ACK, INT_REQ, NMI_ACT;
    logic [4:0]  INT_LVL;
    logic [7:0]  INT_VEC;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    intc_onchip dut (
        .CLK(CLK), .RST(RST), .CE_R(CE_R), .CE_F(CE_F), .RES_N(RES_N),
        .IBUS_A(IBUS_A), .IBUS_DI(IBUS_DI), .IBUS_DO(IBUS_DO), .IBUS_BA(IBUS_BA),
        .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ), .IBUS_BUSY(IBUS_BUSY), .IBUS_ACT(IBUS_ACT),
        .NMI(NMI), .IRL(IRL),
        .FRT_ICI(FRT_ICI), .FRT_OCIA(FRT_OCIA), .FRT_OCIB(FRT_OCIB), .FRT_OVI(FRT_OVI),
        .WDT_ITI(WDT_ITI), .BSC_CMI(BSC_CMI), .SCI_ERI(SCI_ERI), .SCI_RXI(SCI_RXI),
        .SCI_TXI(SCI_TXI), .SCI_TEI(SCI_TEI),
        .DIVU_IRQ(DIVU_IRQ), .DMA0_IRQ(DMA0_IRQ), .DMA1_IRQ(DMA1_IRQ),
        .DIVU_VEC(DIVU_VEC), .DMA0_VEC(DMA0_VEC), .DMA1_VEC(DMA1_VEC),
        .INT_ACK(INT_ACK), .INT_REQ(INT_REQ), .INT_LVL(INT_LVL), .INT_VEC(INT_VEC),
        .NMI_ACT(NMI_ACT)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [15:0] d, input logic [1:0] be);
        IBUS_A   = addr;
        IBUS_DI  = {d, d};
        IBUS_BA  = addr[1] ? {2'b00, be} : {be, 2'b00};
        IBUS_WE  = 1'b1;
        IBUS_REQ = 1'b1;
        tick();
        IBUS_WE  = 1'b0;
        IBUS_REQ = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [31:0] addr, input logic [15:0] exp,
                            input logic exp_act);
        IBUS_A   = addr;
        IBUS_WE  = 1'b0;
        IBUS_REQ = 1'b1;
        #1;
        check({tag, "_act"}, {31'd0, IBUS_ACT}, {31'd0, exp_act});
        tick();
        check(tag, IBUS_DO, exp_act ? {exp, exp} : 32'd0);
        IBUS_REQ = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic req, input logic [4:0] lvl,
                             input logic [7:0] vec);
        check({tag, "_req"}, {31'd0, INT_REQ}, {31'd0, req});
        check({tag, "_lvl"}, {27'd0, INT_LVL}, {27'd0, lvl});
        check({tag, "_vec"}, {24'd0, INT_VEC}, {24'd0, vec});
    endtask

    initial begin
        RST = 1'b1; CE_R = 1'b1; CE_F = 1'b1; RES_N = 1'b1;
        IBUS_A = '0; IBUS_DI = '0; IBUS_BA = '0; IBUS_WE = 1'b0; IBUS_REQ = 1'b0;
        NMI = 1'b0; IRL = 4'hF;
        FRT_ICI = 0; FRT_OCIA = 0; FRT_OCIB = 0; FRT_OVI = 0;
        WDT_ITI = 0; BSC_CMI = 0; SCI_ERI = 0; SCI_RXI = 0; SCI_TXI = 0; SCI_TEI = 0;
        DIVU_IRQ = 0; DMA0_IRQ = 0; DMA1_IRQ = 0;
        DIVU_VEC = 8'h30; DMA0_VEC = 8'h31; DMA1_VEC = 8'h32;
        INT_ACK = 1'b0;

        #12;
        check_out("rst", 1'b0, 5'd0, 8'd0);
        check("rst_do", IBUS_DO, 32'd0);
        check("rst_nmi", {31'd0, NMI_ACT}, 32'd0);
        check("busy", {31'd0, IBUS_BUSY}, 32'd0);
        @(posedge CLK); #1; RST = 1'b0;
        tick();

        bus_read("ipra_rst", 32'hFFFFFEE2, 16'h0000, 1'b1);
        bus_read("icr_rst", 32'hFFFFFEE0, 16'h0000, 1'b1);
        bus_read("unmapped", 32'hFFFFFEE6, 16'h0000, 1'b0);
        tick();

        bus_write(32'hFFFFFEE2, 16'hFFFF, 2'b11);
        bus_read("ipra_mask", 32'hFFFFFEE2, 16'hFFF0, 1'b1);
        bus_write(32'hFFFFFEE2, 16'h1234, 2'b10);
        bus_read("ipra_lane", 32'hFFFFFEE2, 16'h12F0, 1'b1);
        bus_write(32'hFFFFFEE2, 16'h0000, 2'b11);

        bus_write(32'hFFFFFE60, 16'h0500, 2'b11);
        bus_write(32'hFFFFFE66, 16'h0048, 2'b11);
        bus_read("vcrc", 32'hFFFFFE66, 16'h0048, 1'b1);
        FRT_OCIB = 1'b1;
        check("oci_latency", {31'd0, INT_REQ}, 32'd0);
        tick();
        check_out("ocib", 1'b1, 5'd5, 8'h48);
        FRT_OCIB = 1'b0;
        tick();
        check("oci_drop", {31'd0, INT_REQ}, 32'd0);

        bus_write(32'hFFFFFEE2, 16'h0070, 2'b11);
        bus_write(32'hFFFFFE60, 16'h7500, 2'b11);
        bus_write(32'hFFFFFEE4, 16'h5152, 2'b11);
        bus_write(32'hFFFFFE62, 16'h6061, 2'b11);
        WDT_ITI = 1'b1; SCI_RXI = 1'b1;
        tick();
        check_out("tie", 1'b1, 5'd7, 8'h51);
        WDT_ITI = 1'b0;
        tick();
        check_out("rxi", 1'b1, 5'd7, 8'h61);
        SCI_RXI = 1'b0;
        tick();

        IRL = 4'h6;
        tick();
        check_out("irl_auto", 1'b1, 5'd9, 8'd68);
        bus_write(32'hFFFFFEE0, 16'h0001, 2'b11);
        tick();
        check_out("irl_ext", 1'b1, 5'd9, 8'd73);
        bus_read("icr_vecmd", 32'hFFFFFEE0, 16'h0001, 1'b1);
        bus_write(32'hFFFFFEE0, 16'h0000, 2'b11);

        IRL = 4'h0; NMI = 1'b1;
        tick();
        tick();
        check("nmi_rise_ign", {31'd0, NMI_ACT}, 32'd0);
        check_out("irl15", 1'b1, 5'd15, 8'd71);
        bus_read("icr_nmil", 32'hFFFFFEE0, 16'h8000, 1'b1);
        NMI = 1'b0;
        tick();
        check("nmi_fall", {31'd0, NMI_ACT}, 32'd1);
        tick();
        check_out("nmi", 1'b1, 5'd16, 8'd11);
        INT_ACK = 1'b1;
        tick();
        INT_ACK = 1'b0;
        check_out("ack_hold", 1'b1, 5'd16, 8'd11);
        check("ack_clr", {31'd0, NMI_ACT}, 32'd0);
        tick();
        check_out("after_ack", 1'b1, 5'd15, 8'd71);

        bus_write(32'hFFFFFEE0, 16'h0100, 2'b11);
        NMI = 1'b1;
        tick();
        check("nmi_rise", {31'd0, NMI_ACT}, 32'd1);
        tick();
        check("nmi_rise_lvl", {27'd0, INT_LVL}, 32'd16);
        NMI = 1'b0;
        tick();
        NMI = 1'b1; INT_ACK = 1'b1;
        tick();
        INT_ACK = 1'b0;
        check("edge_vs_ack", {31'd0, NMI_ACT}, 32'd1);
        tick();
        check("edge_vs_ack_lvl", {27'd0, INT_LVL}, 32'd16);
        INT_ACK = 1'b1;
        tick();
        INT_ACK = 1'b0;
        tick();
        check_out("nmi_done", 1'b1, 5'd15, 8'd71);

        RES_N = 1'b0;
        tick();
        check_out("soft_rst", 1'b0, 5'd0, 8'd0);
        RES_N = 1'b1;
        tick();
        check("soft_rel", {27'd0, INT_LVL}, 32'd15);
        IRL = 4'hF;
        tick();
        bus_read("iprb_soft", 32'hFFFFFE60, 16'h0000, 1'b1);

        FRT_OVI = 1'b1;
        tick();
        tick();
        check("ovi_masked", {31'd0, INT_REQ}, 32'd0);
        bus_write(32'hFFFFFE60, 16'h0300, 2'b11);
        bus_write(32'hFFFFFE68, 16'h4A00, 2'b11);
        tick();
        check_out("ovi", 1'b1, 5'd3, 8'h4A);
        @(posedge CLK); #3;
        RST = 1'b1;
        #1;
        check_out("async_rst", 1'b0, 5'd0, 8'd0);
        check("async_rst_do", IBUS_DO, 32'd0);
        tick();
        RST = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
